// File: rtl/bp_pkg.sv
// Shared encodings and geometry helpers for the parametrised branch predictor.
package bp_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

    localparam ctr_e CTR_RESET = WNT;
    localparam ctr_e CTR_ALLOC = WT;

    function automatic int bp_idx_w(input int entries);
        return $clog2(entries);
    endfunction

    // Two low PC bits are the word offset and never take part in index or tag.
    function automatic int bp_tag_w(input int pc_w, input int entries);
        return pc_w - $clog2(entries) - 2;
    endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// 2-bit saturating up/down next-state logic shared by BTB counters and the PHT.
module bp_sat_counter
    import bp_pkg::*;
(
    input  logic [1:0] ctr,
    input  logic       inc,
    output logic [1:0] ctr_next
);

    always_comb begin
        // NOTE: default assignment first so no path through the block leaves ctr_next unassigned (no latch).
        ctr_next = ctr;
        if (inc) begin
            if (ctr != ST) ctr_next = ctr + 2'd1;
        end else begin
            if (ctr != SNT) ctr_next = ctr - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor_param.sv
// Direct-mapped BTB with 2-bit direction counters and saturating perf counters.
// Define BP_GSHARE_EN to index the direction counters by pc index XOR global history.
module branch_predictor_param
    import bp_pkg::*;
#(
    parameter int PC_W    = 8,
    parameter int ENTRIES = 16,
    parameter int PERF_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PC_W-1:0]   pc,
    input  logic              upd_valid,
    input  logic [PC_W-1:0]   upd_pc,
    input  logic              upd_taken,
    input  logic [PC_W-1:0]   upd_target,
    input  logic              upd_mispredict,
    input  logic              stall,
    output logic              hit,
    output logic              taken,
    output logic [PC_W-1:0]   pc_predicted,
    output logic [PERF_W-1:0] upd_count,
    output logic [PERF_W-1:0] mispred_count
);

    localparam int IDX_W = bp_idx_w(ENTRIES);
    localparam int TAG_W = bp_tag_w(PC_W, ENTRIES);

    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [PC_W-1:0]  target_q [ENTRIES];
    logic [1:0]       dir_q    [ENTRIES];

    logic [IDX_W-1:0] idx, upd_idx, dir_idx, upd_dir_idx;
    logic [TAG_W-1:0] tag, upd_tag;
    logic             upd_accept, upd_hit;
    logic [1:0]       dir_next;
    logic [PERF_W-1:0] upd_count_q, mispred_count_q;

    assign idx     = pc[IDX_W+1:2];
    assign tag     = pc[PC_W-1:IDX_W+2];
    assign upd_idx = upd_pc[IDX_W+1:2];
    assign upd_tag = upd_pc[PC_W-1:IDX_W+2];

`ifdef BP_GSHARE_EN
    logic [IDX_W-1:0] ghr_q;

    assign dir_idx     = idx ^ ghr_q;
    assign upd_dir_idx = upd_idx ^ ghr_q;

    always_ff @(posedge clk) begin
        if (rst)             ghr_q <= '0;
        else if (upd_accept) ghr_q <= {ghr_q[IDX_W-2:0], upd_taken};
    end
`else
    assign dir_idx     = idx;
    assign upd_dir_idx = upd_idx;
`endif

    assign upd_accept = upd_valid && !stall;
    assign upd_hit    = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

    bp_sat_counter u_sat (
        .ctr      (dir_q[upd_dir_idx]),
        .inc      (upd_taken),
        .ctr_next (dir_next)
    );

    // Lookup reads pre-edge state, so a same-cycle update is visible one cycle later.
    assign hit          = valid_q[idx] && (tag_q[idx] == tag);
    assign taken        = hit && dir_q[dir_idx][1];
    assign pc_predicted = taken ? target_q[idx] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the table is reset entry by entry because lookups depend on valid and counter values from the first cycle.
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                dir_q[i]    <= CTR_RESET;
            end
        end else if (upd_accept) begin
            // NOTE: non-blocking assignments so every register here samples pre-edge values.
            if (upd_hit) begin
                dir_q[upd_dir_idx] <= dir_next;
                if (upd_taken) target_q[upd_idx] <= upd_target;
            end else if (upd_taken) begin
                valid_q[upd_idx]   <= 1'b1;
                tag_q[upd_idx]     <= upd_tag;
                target_q[upd_idx]  <= upd_target;
                dir_q[upd_dir_idx] <= CTR_ALLOC;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            upd_count_q     <= '0;
            mispred_count_q <= '0;
        end else if (upd_accept) begin
            if (upd_count_q != '1) upd_count_q <= upd_count_q + 1'b1;
            if (upd_mispredict && (mispred_count_q != '1))
                mispred_count_q <= mispred_count_q + 1'b1;
        end
    end

    assign upd_count     = upd_count_q;
    assign mispred_count = mispred_count_q;

endmodule

// File: tb/tb_branch_predictor_param.sv
// Directed bench: a default instance plus a PERF_W=2 instance sharing the same stimulus.
module tb_branch_predictor_param;

    logic        clk = 1'b0;
    logic        rst, upd_valid, upd_taken, upd_mispredict, stall;
    logic [7:0]  pc, upd_pc, upd_target;
    logic        hit, taken, hit2, taken2;
    logic [7:0]  pc_predicted, pc_predicted2;
    logic [15:0] upd_count, mispred_count;
    logic [1:0]  upd_count2, mispred_count2;

    int checks = 0;
    int errors = 0;

    branch_predictor_param #(.PC_W(8), .ENTRIES(16), .PERF_W(16)) dut (
        .clk(clk), .rst(rst), .pc(pc), .upd_valid(upd_valid), .upd_pc(upd_pc),
        .upd_taken(upd_taken), .upd_target(upd_target), .upd_mispredict(upd_mispredict),
        .stall(stall), .hit(hit), .taken(taken), .pc_predicted(pc_predicted),
        .upd_count(upd_count), .mispred_count(mispred_count)
    );

    branch_predictor_param #(.PC_W(8), .ENTRIES(16), .PERF_W(2)) dut_p2 (
        .clk(clk), .rst(rst), .pc(pc), .upd_valid(upd_valid), .upd_pc(upd_pc),
        .upd_taken(upd_taken), .upd_target(upd_target), .upd_mispredict(upd_mispredict),
        .stall(stall), .hit(hit2), .taken(taken2), .pc_predicted(pc_predicted2),
        .upd_count(upd_count2), .mispred_count(mispred_count2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic lookup(input logic [7:0] p);
        pc = p;
        #1;
    endtask

    // One accepted (or stalled) update; returns 1 time unit after the edge.
    task automatic upd(input logic [7:0] p, input logic t, input logic [7:0] tgt, input logic m);
        upd_valid      = 1'b1;
        upd_pc         = p;
        upd_taken      = t;
        upd_target     = tgt;
        upd_mispredict = m;
        @(posedge clk);
        #1;
        upd_valid      = 1'b0;
        upd_mispredict = 1'b0;
    endtask

    initial begin
        rst = 1'b1; upd_valid = 1'b0; upd_taken = 1'b0; upd_mispredict = 1'b0;
        stall = 1'b0; pc = 8'h00; upd_pc = 8'h00; upd_target = 8'h00;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        lookup(8'h10);
        check("rst_hit", hit, 0);
        check("rst_taken", taken, 0);
        check("rst_pred", pc_predicted, 8'h00);
        check("rst_upd_cnt", upd_count, 0);
        check("rst_mis_cnt", mispred_count, 0);

        // Allocate 0x10 -> 0x40; same-cycle lookup still sees the old table
        upd_valid = 1'b1; upd_pc = 8'h10; upd_taken = 1'b1; upd_target = 8'h40;
        pc = 8'h10;
        #1;
        check("rdw_hit", hit, 0);
        check("rdw_taken", taken, 0);
        @(posedge clk);
        #1 upd_valid = 1'b0;
        check("alloc_hit", hit, 1);
        check("alloc_taken", taken, 1);
        check("alloc_pred", pc_predicted, 8'h40);
        check("alloc_upd_cnt", upd_count, 1);

        // Counter walk: 10 -> 01 -> 00 -> 01 -> 10
        upd(8'h10, 1'b0, 8'h00, 1'b1);
        check("nt1_hit", hit, 1);
        check("nt1_taken", taken, 0);
        check("nt1_pred", pc_predicted, 8'h00);
        check("nt1_mis_cnt", mispred_count, 1);
        upd(8'h10, 1'b0, 8'h00, 1'b0);
        check("nt2_hit", hit, 1);
        check("nt2_taken", taken, 0);
        upd(8'h10, 1'b1, 8'h40, 1'b0);
        check("t1_taken", taken, 0);
        upd(8'h10, 1'b1, 8'h44, 1'b0);
        check("t2_taken", taken, 1);
        check("t2_pred", pc_predicted, 8'h44);
        check("walk_upd_cnt", upd_count, 5);

        // Alias: 0x50 shares index 4 with tag 1 and replaces the entry
        upd(8'h50, 1'b1, 8'h80, 1'b0);
        lookup(8'h10);
        check("alias_old_hit", hit, 0);
        check("alias_old_taken", taken, 0);
        lookup(8'h50);
        check("alias_new_hit", hit, 1);
        check("alias_new_taken", taken, 1);
        check("alias_new_pred", pc_predicted, 8'h80);

        // Stall freezes everything, including perf counters
        stall = 1'b1;
        upd(8'h20, 1'b1, 8'h90, 1'b1);
        stall = 1'b0;
        lookup(8'h20);
        check("stall_hit", hit, 0);
        check("stall_upd_cnt", upd_count, 6);
        check("stall_mis_cnt", mispred_count, 1);
        upd(8'h24, 1'b0, 8'h00, 1'b0);
        lookup(8'h24);
        check("ntmiss_hit", hit, 0);
        check("ntmiss_upd_cnt", upd_count, 7);

        // Perf saturation on the narrow instance
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("rst2_upd_cnt2", upd_count2, 0);
        check("rst2_mis_cnt2", mispred_count2, 0);
        lookup(8'h50);
        check("rst2_hit", hit, 0);
        for (int n = 1; n <= 5; n++) begin
            upd(8'h10, 1'b1, 8'h40, 1'b1);
            check("sat_upd_cnt2", upd_count2, (n > 3) ? 3 : n);
            check("sat_mis_cnt2", mispred_count2, (n > 3) ? 3 : n);
            check("sat_upd_cnt", upd_count, n);
        end
        lookup(8'h10);
        check("pre_rst_hit2", hit2, 1);

        // Reset wins over a simultaneous update
        rst = 1'b1;
        upd(8'h30, 1'b1, 8'hA0, 1'b1);
        rst = 1'b0;
        check("rstupd_upd_cnt2", upd_count2, 0);
        check("rstupd_mis_cnt2", mispred_count2, 0);
        check("rstupd_upd_cnt", upd_count, 0);
        lookup(8'h10);
        check("rstupd_hit_10", hit, 0);
        check("rstupd_hit2_10", hit2, 0);
        lookup(8'h30);
        check("rstupd_hit_30", hit, 0);
        check("rstupd_taken_30", taken, 0);
        check("rstupd_pred_30", pc_predicted, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
